gate_state_mac_seq: RTL and testbench
=====================================

# gate_state_mac_seq

Sequential, fully complex successor to the combinational real-only gate/state multiplier. It computes outState = G·state, or G†·state in adjoint mode, for an N-qubit register using a single time-multiplexed complex multiply-accumulate unit. The block uses signed fixed point with round-to-nearest and saturation, and a start/busy/done handshake. It sits between the gate-sequencing FSM and the state register, trading latency for one complex MAC instead of 4^N multipliers.

## Interface
- N, default 2: qubit count; D = 2**N state elements, D×D gate elements.
- W, default 16: element width, signed two's complement.
- F, default 14: fraction bits (Q(W-F).F); 1.0 = 0x4000 at defaults.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Assertion forces the reset state immediately; release is synchronous to clk.
- start  in  1  request; sampled only in IDLE.
- adj  in  1  0: use G; 1: use conj-transpose G† (element (r,c) = conj(G[c][r])). Captured with start.
- gate_re, gate_im  in  D*D*W  element (r,c) at bits [(r*D+c)*W +: W].
- state_re, state_im  in  D*W  element c at bits [c*W +: W].
- busy  out  1  high in MAC and WRITE states.
- done  out  1  one-cycle pulse; results valid from this cycle.
- out_re, out_im  out  D*W  result vector, same packing as state.
- ovf  out  1  at least one output component saturated in the last completed operation.

## Operation
- States: IDLE, MAC, WRITE, DONE.
  - IDLE: if start=1, capture gate, state and adj into internal registers, clear the accumulator, set row=0 and col=0, and go to MAC. Otherwise stay.
  - MAC: one complex product term per cycle.
    - acc_re += gr·sr − gi·si
    - acc_im += gr·si + gi·sr
    - Operands are g = the selected gate element (r,col) (conjugated/transposed if adj) and s = state[col].
    - col increments each cycle. After col = D−1 is processed, go to WRITE.
  - WRITE: round and saturate acc_re/acc_im into staging entry [row], then clear acc and col.
    - If row = D−1, go to DONE.
    - Otherwise increment row and return to MAC.
  - DONE: done=1. Go to IDLE next edge.
- Arithmetic:
  - Products are full 2W-bit signed values.
  - Accumulator width is 2W+N+1, which cannot overflow.
  - Conjugation negates gi and must handle gi = −2^(W−1) without wrap; the accumulator width absorbs it.
  - Rounding: add 2^(F−1), then arithmetic shift right by F (round half up).
  - Saturation: clamp to [−2^(W−1), 2^(W−1)−1]. Any clamp sets an internal sticky flag, which is cleared on capture.
- Output update: out_re, out_im and ovf are loaded from the staging buffer and the sticky flag on the edge entering DONE. They hold otherwise, so outputs stay stable and show the previous result throughout an operation.
- Input changes after capture have no effect on the current operation.
- start while busy, or in DONE: ignored, not queued.
- Reset (asynchronous, any state, including mid-operation): state=IDLE; busy, done, ovf = 0; out_re, out_im, accumulator, staging and counters = 0. No done is produced for the aborted operation.

## Timing
- The start edge t0 is the rising edge that samples start=1 in IDLE.
- busy is high in the cycles after edges t0 … t0+D(D+1)−1.
- done is high for exactly one cycle: after edge t0+D(D+1). Outputs are valid in that cycle.
- Latency from start to done is D(D+1) cycles: 6 for N=1, 20 for N=2.
- Back-to-back operation: the earliest next start is sampled at edge t0+D(D+1)+1 (IDLE), giving throughput of one operation per D(D+1)+1 cycles.
- After reset release, IDLE is entered immediately. A start on the first edge is accepted.

## Test plan
- Identity, N=2: G=I (diagonal 0x4000), state_re=(0x1000, 0x2000, 0xE000, 0), state_im=(0, 0x0100, 0, 0x7FFF) -> out equals state exactly, ovf=0, done at t0+20, busy high for 20 cycles.
- Hadamard, N=1: all G_re = 0x2D41 except G[1][1] = 0xD2BF; state = (0x4000, 0) -> out_re = (0x2D41, 0x2D41), out_im = 0, done at t0+6.
- Adjoint phase, N=1: G = diag(1.0, i) (G_im[1][1] = 0x4000), state = (0, 0x4000 real).
  - adj=0 -> out_im[1] = 0x4000.
  - adj=1 -> out_im[1] = 0xC000.
  - All other components 0 in both cases.
- Saturation, N=1: all G_re = 0x4000, state_re = (0x6000, 0x6000) -> out_re = (0x7FFF, 0x7FFF), ovf=1. A following operation with no clamp -> ovf=0.
- Reset mid-operation: assert reset at cycle 7 of an N=2 operation -> outputs, busy and done are 0 immediately and no done pulse follows. A new start after release completes normally in 20 cycles.
- Start while busy, plus input change after capture: pulse start at t0+3 and alter gate_re -> ignored, result matches the captured inputs, exactly one done pulse.

Source files
------------

// File: rtl/gate_state_mac_seq.sv
// Sequential complex gate/state multiplier: out = G*state (or G^dagger*state when adjoint)
// using a single time-multiplexed complex MAC, with round-half-up and saturation.
module gate_state_mac_seq #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 16,
  parameter int unsigned F = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_adj,
  input  logic [(W<<(2*N))-1:0] i_gate_re,
  input  logic [(W<<(2*N))-1:0] i_gate_im,
  input  logic [(W<<N)-1:0]     i_state_re,
  input  logic [(W<<N)-1:0]     i_state_im,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [(W<<N)-1:0]     o_out_re,
  output logic [(W<<N)-1:0]     o_out_im,
  output logic                  o_ovf
);

  localparam int unsigned D  = 2**N;
  localparam int unsigned PW = 2*W + 1;
  localparam int unsigned AW = 2*W + N + 1;

  localparam logic signed [AW-1:0] RndC   = {{(AW-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
  localparam logic signed [AW-1:0] SatMax = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SatMin = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StWrite, StDone} state_e;

  state_e r_state, w_state_next;

  logic signed [W-1:0]  r_g_re [D*D];
  logic signed [W-1:0]  r_g_im [D*D];
  logic signed [W-1:0]  r_s_re [D];
  logic signed [W-1:0]  r_s_im [D];
  logic signed [W-1:0]  r_stg_re [D];
  logic signed [W-1:0]  r_stg_im [D];
  logic signed [W-1:0]  r_out_re [D];
  logic signed [W-1:0]  r_out_im [D];
  logic                 r_adj;
  logic [N-1:0]         r_row, r_col;
  logic signed [AW-1:0] r_acc_re, r_acc_im;
  logic                 r_sticky;
  logic                 r_ovf;

  logic                 w_last_col, w_last_row;
  logic [2*N-1:0]       w_gidx;
  logic signed [W-1:0]  w_gr, w_gi_raw, w_sr, w_si;
  logic signed [W:0]    w_gi;
  logic signed [PW-1:0] w_gr_x, w_gi_x, w_sr_x, w_si_x;
  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [AW-1:0] w_term_re, w_term_im;
  logic [W:0]           w_sat_re, w_sat_im;

  assign w_last_col = (r_col == {N{1'b1}});
  assign w_last_row = (r_row == {N{1'b1}});

  // Adjoint reads the transposed element; {row,col} is row*D+col.
  assign w_gidx   = r_adj ? {r_col, r_row} : {r_row, r_col};
  assign w_gr     = r_g_re[w_gidx];
  assign w_gi_raw = r_g_im[w_gidx];
  assign w_sr     = r_s_re[r_col];
  assign w_si     = r_s_im[r_col];

  // One extra bit so negating the most-negative imaginary part cannot wrap.
  assign w_gi = r_adj ? -{w_gi_raw[W-1], w_gi_raw} : {w_gi_raw[W-1], w_gi_raw};

  assign w_gr_x = {{(PW-W){w_gr[W-1]}}, w_gr};
  assign w_gi_x = {{(PW-W-1){w_gi[W]}}, w_gi};
  assign w_sr_x = {{(PW-W){w_sr[W-1]}}, w_sr};
  assign w_si_x = {{(PW-W){w_si[W-1]}}, w_si};

  assign w_p_rr = w_gr_x * w_sr_x;
  assign w_p_ii = w_gi_x * w_si_x;
  assign w_p_ri = w_gr_x * w_si_x;
  assign w_p_ir = w_gi_x * w_sr_x;

  assign w_term_re = {{(AW-PW){w_p_rr[PW-1]}}, w_p_rr} - {{(AW-PW){w_p_ii[PW-1]}}, w_p_ii};
  assign w_term_im = {{(AW-PW){w_p_ri[PW-1]}}, w_p_ri} + {{(AW-PW){w_p_ir[PW-1]}}, w_p_ir};

  // Returns {clamped, value}.
  function automatic logic [W:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] q;
    q = (a + RndC) >>> F;
    if (q > SatMax) begin
      return {1'b1, 1'b0, {(W-1){1'b1}}};
    end else if (q < SatMin) begin
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    end
    return {1'b0, q[W-1:0]};
  endfunction

  assign w_sat_re = round_sat(r_acc_re);
  assign w_sat_im = round_sat(r_acc_im);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StMac;
      StMac:   if (w_last_col) w_state_next = StWrite;
      StWrite: w_state_next = w_last_row ? StDone : StMac;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < D*D; i++) begin
        r_g_re[i] <= '0;
        r_g_im[i] <= '0;
      end
      for (int unsigned i = 0; i < D; i++) begin
        r_s_re[i]   <= '0;
        r_s_im[i]   <= '0;
        r_stg_re[i] <= '0;
        r_stg_im[i] <= '0;
        r_out_re[i] <= '0;
        r_out_im[i] <= '0;
      end
      r_adj    <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            for (int unsigned i = 0; i < D*D; i++) begin
              r_g_re[i] <= i_gate_re[i*W +: W];
              r_g_im[i] <= i_gate_im[i*W +: W];
            end
            for (int unsigned i = 0; i < D; i++) begin
              r_s_re[i] <= i_state_re[i*W +: W];
              r_s_im[i] <= i_state_im[i*W +: W];
            end
            r_adj    <= i_adj;
            r_row    <= '0;
            r_col    <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_sticky <= 1'b0;
          end
        end
        StMac: begin
          r_acc_re <= r_acc_re + w_term_re;
          r_acc_im <= r_acc_im + w_term_im;
          r_col    <= r_col + N'(1);
        end
        StWrite: begin
          r_stg_re[r_row] <= w_sat_re[W-1:0];
          r_stg_im[r_row] <= w_sat_im[W-1:0];
          r_sticky        <= r_sticky | w_sat_re[W] | w_sat_im[W];
          r_acc_re        <= '0;
          r_acc_im        <= '0;
          r_col           <= '0;
          if (w_last_row) begin
            // Last row bypasses staging so outputs update on the edge entering DONE.
            for (int unsigned i = 0; i < D; i++) begin
              if (i == D-1) begin
                r_out_re[i] <= w_sat_re[W-1:0];
                r_out_im[i] <= w_sat_im[W-1:0];
              end else begin
                r_out_re[i] <= r_stg_re[i];
                r_out_im[i] <= r_stg_im[i];
              end
            end
            r_ovf <= r_sticky | w_sat_re[W] | w_sat_im[W];
          end else begin
            r_row <= r_row + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state == StMac) || (r_state == StWrite);
  assign o_done = (r_state == StDone);
  assign o_ovf  = r_ovf;

  for (genvar g = 0; g < D; g++) begin : g_out
    assign o_out_re[g*W +: W] = r_out_re[g];
    assign o_out_im[g*W +: W] = r_out_im[g];
  end

endmodule

// File: tb/tb_gate_state_mac_seq.sv
// Bench for gate_state_mac_seq: directed cases at N=1 and N=2 plus randomized operations
// checked against an arithmetic matrix-vector reference model.
module tb_gate_state_mac_seq;
  localparam int W = 16;
  localparam int F = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst2_n, start2, adj2, busy2, done2, ovf2;
  logic [16*W-1:0] g2_re, g2_im;
  logic [4*W-1:0] s2_re, s2_im, o2_re, o2_im;
  logic           rst1_n, start1, adj1, busy1, done1, ovf1;
  logic [4*W-1:0] g1_re, g1_im;
  logic [2*W-1:0] s1_re, s1_im, o1_re, o1_im;

  gate_state_mac_seq #(.N(2), .W(W), .F(F)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .i_start(start2), .i_adj(adj2),
    .i_gate_re(g2_re), .i_gate_im(g2_im), .i_state_re(s2_re), .i_state_im(s2_im),
    .o_busy(busy2), .o_done(done2), .o_out_re(o2_re), .o_out_im(o2_im), .o_ovf(ovf2)
  );

  gate_state_mac_seq #(.N(1), .W(W), .F(F)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_start(start1), .i_adj(adj1),
    .i_gate_re(g1_re), .i_gate_im(g1_im), .i_state_re(s1_re), .i_state_im(s1_im),
    .o_busy(busy1), .o_done(done1), .o_out_re(o1_re), .o_out_im(o1_im), .o_ovf(ovf1)
  );

  int n_checks = 0;
  int n_errors = 0;

  int mg_re[4][4], mg_im[4][4], ms_re[4], ms_im[4];
  int exp_re[4], exp_im[4];
  bit exp_ovf;

  function automatic int rnd_sat(input longint a);
    longint q;
    q = (a + (longint'(1) << (F-1))) >>> F;
    if (q > 32767) begin exp_ovf = 1'b1; return 32767; end
    if (q < -32768) begin exp_ovf = 1'b1; return -32768; end
    return int'(q);
  endfunction

  // out[r] = sum_c g(r,c)*s[c], g = G[r][c] or conj(G[c][r]).
  function automatic void model(input int d, input bit adj);
    longint ar, ai, gr, gi;
    exp_ovf = 1'b0;
    for (int r = 0; r < d; r++) begin
      ar = 0;
      ai = 0;
      for (int c = 0; c < d; c++) begin
        gr = adj ? mg_re[c][r] : mg_re[r][c];
        gi = adj ? -longint'(mg_im[c][r]) : longint'(mg_im[r][c]);
        ar += gr * ms_re[c] - gi * ms_im[c];
        ai += gr * ms_im[c] + gi * ms_re[c];
      end
      exp_re[r] = rnd_sat(ar);
      exp_im[r] = rnd_sat(ai);
    end
  endfunction

  task automatic rand_load(input bit one, input int shift);
    int d;
    logic signed [W-1:0] v;
    d = one ? 2 : 4;
    for (int r = 0; r < d; r++) begin
      for (int c = 0; c < d; c++) begin
        v = W'($urandom); mg_re[r][c] = int'(v) >>> shift;
        v = W'($urandom); mg_im[r][c] = int'(v) >>> shift;
        if (one) begin
          g1_re[(r*2+c)*W +: W] = mg_re[r][c][W-1:0];
          g1_im[(r*2+c)*W +: W] = mg_im[r][c][W-1:0];
        end else begin
          g2_re[(r*4+c)*W +: W] = mg_re[r][c][W-1:0];
          g2_im[(r*4+c)*W +: W] = mg_im[r][c][W-1:0];
        end
      end
      v = W'($urandom); ms_re[r] = int'(v) >>> shift;
      v = W'($urandom); ms_im[r] = int'(v) >>> shift;
      if (one) begin
        s1_re[r*W +: W] = ms_re[r][W-1:0];
        s1_im[r*W +: W] = ms_im[r][W-1:0];
      end else begin
        s2_re[r*W +: W] = ms_re[r][W-1:0];
        s2_im[r*W +: W] = ms_im[r][W-1:0];
      end
    end
  endtask

  // Pulse start (optionally held), then watch win cycles sampled on negedges.
  task automatic run_op(input bit one, input bit adj, input int inject_k, input bit hold,
                        input int win, output int fd, output int nd, output int nb,
                        output int nchg);
    logic [4*W-1:0] prev_re, prev_im, cur_re, cur_im;
    prev_re = one ? 64'(o1_re) : o2_re;
    prev_im = one ? 64'(o1_im) : o2_im;
    if (one) begin adj1 = adj; start1 = 1'b1; end
    else begin adj2 = adj; start2 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin start1 = 1'b0; start2 = 1'b0; end
    fd = -1; nd = 0; nb = 0; nchg = 0;
    for (int k = 0; k < win; k++) begin
      cur_re = one ? 64'(o1_re) : o2_re;
      cur_im = one ? 64'(o1_im) : o2_im;
      if (one ? done1 : done2) begin
        nd++;
        if (fd < 0) fd = k;
      end
      if (one ? busy1 : busy2) nb++;
      if (fd < 0 && (cur_re !== prev_re || cur_im !== prev_im)) nchg++;
      if (k == inject_k) begin
        if (one) begin start1 = 1'b1; g1_re = ~g1_re; end
        else begin start2 = 1'b1; g2_re = ~g2_re; end
      end else if (!hold) begin
        start1 = 1'b0; start2 = 1'b0;
      end
      @(negedge clk);
    end
    start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst2_n = 1'b0; rst1_n = 1'b0;
    start2 = 1'b0; adj2 = 1'b0; g2_re = '0; g2_im = '0; s2_re = '0; s2_im = '0;
    start1 = 1'b0; adj1 = 1'b0; g1_re = '0; g1_im = '0; s1_re = '0; s1_im = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy2, done2, ovf2} !== 3'b000 || o2_re !== '0 || o2_im !== '0) begin
      n_errors++;
      $display("FAIL reset_n2: busy/done/ovf=%b out=%h/%h expected 000 and zeros",
               {busy2, done2, ovf2}, o2_re, o2_im);
    end
    n_checks++;
    if ({busy1, done1, ovf1} !== 3'b000 || o1_re !== '0 || o1_im !== '0) begin
      n_errors++;
      $display("FAIL reset_n1: busy/done/ovf=%b out=%h/%h expected 000 and zeros",
               {busy1, done1, ovf1}, o1_re, o1_im);
    end
    rst2_n = 1'b1; rst1_n = 1'b1;
  endtask

  // Starts on the very first edge after reset release.
  task automatic test_identity();
    int fd, nd, nb, nchg;
    g2_re = '0; g2_im = '0;
    for (int i = 0; i < 4; i++) g2_re[(i*4+i)*W +: W] = 16'h4000;
    s2_re = {16'h0000, 16'hE000, 16'h2000, 16'h1000};
    s2_im = {16'h7FFF, 16'h0000, 16'h0100, 16'h0000};
    run_op(1'b0, 1'b0, -1, 1'b0, 44, fd, nd, nb, nchg);
    n_checks++;
    if (fd !== 20 || nd !== 1 || nb !== 20) begin
      n_errors++;
      $display("FAIL identity_timing: done_at=%0d dones=%0d busy=%0d expected 20 1 20", fd, nd, nb);
    end
    n_checks++;
    if (o2_re !== 64'h0000_E000_2000_1000 || o2_im !== 64'h7FFF_0000_0100_0000 || ovf2 !== 1'b0)
    begin
      n_errors++;
      $display("FAIL identity_out: re=%h im=%h ovf=%b expected re=0000e00020001000 im=7fff000001000000 ovf=0",
               o2_re, o2_im, ovf2);
    end
    n_checks++;
    if (nchg !== 0) begin
      n_errors++;
      $display("FAIL identity_hold: outputs changed %0d times before done, expected 0", nchg);
    end
  endtask

  task automatic test_hadamard();
    int fd, nd, nb, nchg;
    g1_re = {16'hD2BF, 16'h2D41, 16'h2D41, 16'h2D41};
    g1_im = '0;
    s1_re = {16'h0000, 16'h4000};
    s1_im = '0;
    run_op(1'b1, 1'b0, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (fd !== 6 || nd !== 1 || nb !== 6) begin
      n_errors++;
      $display("FAIL hadamard_timing: done_at=%0d dones=%0d busy=%0d expected 6 1 6", fd, nd, nb);
    end
    n_checks++;
    if (o1_re !== 32'h2D41_2D41 || o1_im !== 32'h0 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("FAIL hadamard_out: re=%h im=%h ovf=%b expected 2d412d41 0 0", o1_re, o1_im, ovf1);
    end
  endtask

  task automatic test_adjoint();
    int fd, nd, nb, nchg;
    g1_re = {16'h0000, 16'h0000, 16'h0000, 16'h4000};
    g1_im = {16'h4000, 16'h0000, 16'h0000, 16'h0000};
    s1_re = {16'h4000, 16'h0000};
    s1_im = '0;
    run_op(1'b1, 1'b0, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h0 || o1_im !== 32'h4000_0000 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("FAIL adjoint_off: re=%h im=%h ovf=%b expected 0 40000000 0", o1_re, o1_im, ovf1);
    end
    run_op(1'b1, 1'b1, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h0 || o1_im !== 32'hC000_0000 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("FAIL adjoint_on: re=%h im=%h ovf=%b expected 0 c0000000 0", o1_re, o1_im, ovf1);
    end
    // conj of imag -2.0 is +2.0, which must clamp rather than wrap.
    g1_re = '0;
    g1_im = {16'h0000, 16'h0000, 16'h0000, 16'h8000};
    s1_re = {16'h0000, 16'h4000};
    run_op(1'b1, 1'b1, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h0 || o1_im !== 32'h0000_7FFF || ovf1 !== 1'b1) begin
      n_errors++;
      $display("FAIL adjoint_minneg: re=%h im=%h ovf=%b expected 0 00007fff 1", o1_re, o1_im, ovf1);
    end
  endtask

  task automatic test_saturation();
    int fd, nd, nb, nchg;
    g1_re = {4{16'h4000}};
    g1_im = '0;
    s1_re = {16'h6000, 16'h6000};
    s1_im = '0;
    run_op(1'b1, 1'b0, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h7FFF_7FFF || o1_im !== 32'h0 || ovf1 !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_pos: re=%h im=%h ovf=%b expected 7fff7fff 0 1", o1_re, o1_im, ovf1);
    end
    s1_re = {16'hA000, 16'hA000};
    run_op(1'b1, 1'b0, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h8000_8000 || ovf1 !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_neg: re=%h ovf=%b expected 80008000 1", o1_re, ovf1);
    end
    s1_re = {16'h1000, 16'h0800};
    run_op(1'b1, 1'b0, -1, 1'b0, 14, fd, nd, nb, nchg);
    n_checks++;
    if (o1_re !== 32'h1800_1800 || ovf1 !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_clear: re=%h ovf=%b expected 18001800 0", o1_re, ovf1);
    end
  endtask

  task automatic test_random(input bit one, input int iters);
    int fd, nd, nb, nchg, d, lat, win;
    bit adj;
    logic [4*W-1:0] e_re, e_im, got_re, got_im;
    d = one ? 2 : 4;
    lat = d * (d + 1);
    win = 2 * lat + 4;
    for (int it = 0; it < iters; it++) begin
      rand_load(one, (it % 3 == 0) ? 0 : 2 + (it % 2));
      adj = 1'($urandom);
      model(d, adj);
      e_re = '0; e_im = '0;
      for (int r = 0; r < d; r++) begin
        e_re[r*W +: W] = exp_re[r][W-1:0];
        e_im[r*W +: W] = exp_im[r][W-1:0];
      end
      run_op(one, adj, -1, 1'b0, win, fd, nd, nb, nchg);
      got_re = one ? 64'(o1_re) : o2_re;
      got_im = one ? 64'(o1_im) : o2_im;
      n_checks++;
      if (fd !== lat || nd !== 1) begin
        n_errors++;
        $display("FAIL random_timing n=%0d it=%0d: done_at=%0d dones=%0d expected %0d 1",
                 one ? 1 : 2, it, fd, nd, lat);
      end
      n_checks++;
      if (got_re !== e_re || got_im !== e_im || (one ? ovf1 : ovf2) !== exp_ovf) begin
        n_errors++;
        $display("FAIL random_out n=%0d it=%0d adj=%0b: re=%h im=%h ovf=%b expected %h %h %b",
                 one ? 1 : 2, it, adj, got_re, got_im, one ? ovf1 : ovf2, e_re, e_im, exp_ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    logic [4*W-1:0] e_re, e_im;
    rand_load(1'b0, 2);
    adj2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    repeat (6) @(negedge clk);
    rst2_n = 1'b0;
    #1;
    n_checks++;
    if ({busy2, done2, ovf2} !== 3'b000 || o2_re !== '0 || o2_im !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: busy/done/ovf=%b out=%h/%h expected 000 and zeros",
               {busy2, done2, ovf2}, o2_re, o2_im);
    end
    repeat (2) @(negedge clk);
    rst2_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done2 || busy2) nd++;
    end
    n_checks++;
    if (nd !== 0) begin
      n_errors++;
      $display("FAIL reset_no_done: %0d cycles with done/busy after abort, expected 0", nd);
    end
    model(4, 1'b0);
    e_re = '0; e_im = '0;
    for (int r = 0; r < 4; r++) begin
      e_re[r*W +: W] = exp_re[r][W-1:0];
      e_im[r*W +: W] = exp_im[r][W-1:0];
    end
    begin
      int fd, nb, nchg;
      run_op(1'b0, 1'b0, -1, 1'b0, 44, fd, nd, nb, nchg);
      n_checks++;
      if (fd !== 20 || nd !== 1 || o2_re !== e_re || o2_im !== e_im || ovf2 !== exp_ovf) begin
        n_errors++;
        $display("FAIL reset_restart: done_at=%0d dones=%0d re=%h im=%h expected 20 1 %h %h",
                 fd, nd, o2_re, o2_im, e_re, e_im);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int fd, nd, nb, nchg;
    logic [4*W-1:0] e_re, e_im;
    rand_load(1'b0, 2);
    model(4, 1'b1);
    e_re = '0; e_im = '0;
    for (int r = 0; r < 4; r++) begin
      e_re[r*W +: W] = exp_re[r][W-1:0];
      e_im[r*W +: W] = exp_im[r][W-1:0];
    end
    run_op(1'b0, 1'b1, 3, 1'b0, 44, fd, nd, nb, nchg);
    n_checks++;
    if (fd !== 20 || nd !== 1 || nb !== 20) begin
      n_errors++;
      $display("FAIL busy_start_timing: done_at=%0d dones=%0d busy=%0d expected 20 1 20", fd, nd, nb);
    end
    n_checks++;
    if (o2_re !== e_re || o2_im !== e_im || ovf2 !== exp_ovf) begin
      n_errors++;
      $display("FAIL busy_start_out: re=%h im=%h ovf=%b expected %h %h %b",
               o2_re, o2_im, ovf2, e_re, e_im, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int fd, nd, nb, nchg;
    logic [2*W-1:0] e_re, e_im;
    rand_load(1'b1, 2);
    model(2, 1'b0);
    e_re = {exp_re[1][W-1:0], exp_re[0][W-1:0]};
    e_im = {exp_im[1][W-1:0], exp_im[0][W-1:0]};
    run_op(1'b1, 1'b0, -1, 1'b1, 16, fd, nd, nb, nchg);
    n_checks++;
    if (fd !== 6 || nd !== 2) begin
      n_errors++;
      $display("FAIL back_to_back: done_at=%0d dones=%0d expected 6 2", fd, nd);
    end
    n_checks++;
    if (o1_re !== e_re || o1_im !== e_im) begin
      n_errors++;
      $display("FAIL back_to_back_out: re=%h im=%h expected %h %h", o1_re, o1_im, e_re, e_im);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_hadamard();
    test_adjoint();
    test_saturation();
    test_random(1'b0, 8);
    test_random(1'b1, 8);
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
